serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that shares a single full-adder cell across all bits of a WIDTH-bit operand pair. The cell is the propagate/generate form: p = a^b, g = a&b, s = p^cin, cout = g|(p&cin). The controller latches the operands on a start handshake and feeds the cell one bit per clock, LSB first. It registers the carry between bits, assembles the sum in a shift register, and reports completion with a one-cycle done pulse. It sits between a requester (sequencer/testbench) and the shared 1-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock; one clock domain for the whole block
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- cin  input  1  carry-in, sampled on accepted start
- busy  output  1  high while bits are being processed (state RUN)
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result; holds until next accepted start
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE. Encoding is free; no unreachable state may lock up, and any illegal state returns to IDLE.
- IDLE: busy=0, done=0. On start=1, take the following actions:
  - load a_sh<=a, b_sh<=b, carry<=cin, bit counter<=0;
  - clear sum, cout and overflow;
  - go to RUN.
- RUN: each cycle, do the following:
  - feed a_sh[0], b_sh[0] and carry into the full-adder cell;
  - shift a_sh and b_sh right;
  - shift the cell's s into sum from the MSB side, so that after WIDTH shifts bit 0 sits in sum[0];
  - carry<=cell cout;
  - counter++.
- MSB cycle (counter==WIDTH-1): capture carry into the MSB as the overflow term, then cout<=cell cout and overflow<=carry_in_msb ^ cell cout. Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle. If start=1, the next operation is accepted exactly as from IDLE, going directly to RUN. Otherwise go to IDLE.
- start while in RUN is ignored and has no side effects; the operands are not re-sampled.
- Counter width is clog2(WIDTH). The counter never wraps within an operation.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), using the values sampled at accept.
- Reset (synchronous): state<=IDLE and busy=0, done=0, sum=0, cout=0, overflow=0. Shift registers, carry and counter are cleared.
- Reset asserted in RUN aborts the operation: no done pulse and no partial result are exposed. Reset has priority over start in the same cycle.

## Timing
- Accepted start at rising edge k: busy=1 from edge k through edge k+WIDTH.
- Bit i is processed in the cycle following edge k+i, for i = 0..WIDTH-1.
- done=1 in the cycle following edge k+WIDTH. sum, cout and overflow are valid in that cycle and stay stable until the next accept.
- Latency is WIDTH+1 clocks from the start-sampling edge to done visible.
- Throughput is one operation per WIDTH+1 clocks with back-to-back starts (start held high in DONE).
- done and busy are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → after 9 clocks: done pulse, sum=0x96, cout=0, overflow=1; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Also a=0x80, b=0x80 → sum=0x00, cout=1, overflow=1. Also a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Start accepted with a=0x10, b=0x20; at cycle 3 of RUN, drive start=1 with a=0xFF, b=0xFF → required: result sum=0x30 and no restart.
- Back-to-back: start held high through DONE with a new operand pair → second busy rises the cycle after done, with no IDLE cycle. The second result is correct (0x7F+0x01 → 0x80, overflow=1).
- Reset asserted during cycle 4 of RUN → next cycle busy=0, sum=0, cout=0, overflow=0. No done pulse follows. A new start afterwards completes normally.
- Randomized sweep: 1000 random a, b, cin → {cout,sum}==a+b+cin and overflow==(a[7]==b[7])&&(sum[7]!=a[7]). Also repeat the sweep for WIDTH=2 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared p/g full-adder cell, LSB first.
// Ports: clk, reset, start, a, b, cin -> busy, done, sum, cout, overflow.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic accept;
  logic last;
  logic p;
  logic g;
  logic s;
  logic co;

  // shared full-adder cell
  assign p  = a_sh[0] ^ b_sh[0];
  assign g  = a_sh[0] & b_sh[0];
  assign s  = p ^ carry;
  assign co = g | (p & carry);

  always_comb begin
    accept     = 1'b0;
    last       = 1'b0;
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        accept     = start;
        state_next = start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        last       = (cnt == LAST);
        state_next = last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        accept     = start;
        state_next = start ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      // flags decoded from next state so they are true flops
      busy  <= (state_next == S_RUN);
      done  <= (state_next == S_DONE);
      if (accept) begin
        a_sh     <= a;
        b_sh     <= b;
        carry    <= cin;
        cnt      <= '0;
        sum      <= '0;
        cout     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == S_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        sum   <= {s, sum[WIDTH-1:1]};
        carry <= co;
        if (last) begin
          // carry still holds the carry into the MSB here
          cout     <= co;
          overflow <= carry ^ co;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
